// File: rtl/regfile_writeback_buffer.sv
// Writeback FIFO in front of the register file write port, with youngest-match forwarding.
// Define WB_BYPASS_EN to build the forwarding comparators; otherwise hit*/fwd_data* are tied to 0.
module regfile_writeback_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_reg,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     rf_busy,
    output logic [ADDR_W-1:0]        rf_write,
    output logic [DATA_W-1:0]        rf_write_data,
    output logic                     rf_write_enable,
    input  logic [ADDR_W-1:0]        lookup1,
    input  logic [ADDR_W-1:0]        lookup2,
    output logic                     hit1,
    output logic                     hit2,
    output logic [DATA_W-1:0]        fwd_data1,
    output logic [DATA_W-1:0]        fwd_data2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = DEPTH[PTR_W:0];

    logic [ADDR_W-1:0] reg_q  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              empty;
    logic              push;
    logic              pop;

    assign empty           = (count_q == '0);
    assign in_ready        = (count_q < FULL);
    // Writes to $0 complete the handshake but are never queued.
    assign push            = in_valid && in_ready && (in_reg != '0);
    assign pop             = rf_write_enable;
    assign rf_write_enable = !empty && !rf_busy;
    assign rf_write        = empty ? '0 : reg_q[head_q];
    assign rf_write_data   = empty ? '0 : data_q[head_q];
    assign count           = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        if (push) begin
            tail_d = tail_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset: occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            reg_q[tail_q]  <= in_reg;
            data_q[tail_q] <= in_data;
        end
    end

`ifdef WB_BYPASS_EN
    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so the last match found is the youngest one.
    always_comb begin
        hit1      = 1'b0;
        hit2      = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if ((PTR_W+1)'(i) < count_q) begin
                if (lookup1 != '0 && reg_q[idx] == lookup1) begin
                    hit1      = 1'b1;
                    fwd_data1 = data_q[idx];
                end
                if (lookup2 != '0 && reg_q[idx] == lookup2) begin
                    hit2      = 1'b1;
                    fwd_data2 = data_q[idx];
                end
            end
        end
    end
`else
    logic unused_lookup;

    assign unused_lookup = ^{lookup1, lookup2};
    assign hit1          = 1'b0;
    assign hit2          = 1'b0;
    assign fwd_data1     = '0;
    assign fwd_data2     = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback_buffer.sv
// Randomised scoreboard bench for regfile_writeback_buffer; a queue holds pending writes in order.
module tb_regfile_writeback_buffer;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [ADDR_W-1:0] in_reg = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              rf_busy = 1'b0;
    logic [ADDR_W-1:0] rf_write;
    logic [DATA_W-1:0] rf_write_data;
    logic              rf_write_enable;
    logic [ADDR_W-1:0] lookup1 = '0;
    logic [ADDR_W-1:0] lookup2 = '0;
    logic              hit1, hit2;
    logic [DATA_W-1:0] fwd_data1, fwd_data2;
    logic [$clog2(DEPTH):0] count;

    regfile_writeback_buffer #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_reg          (in_reg),
        .in_data         (in_data),
        .rf_busy         (rf_busy),
        .rf_write        (rf_write),
        .rf_write_data   (rf_write_data),
        .rf_write_enable (rf_write_enable),
        .lookup1         (lookup1),
        .lookup2         (lookup2),
        .hit1            (hit1),
        .hit2            (hit2),
        .fwd_data1       (fwd_data1),
        .fwd_data2       (fwd_data2),
        .count           (count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] r;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t model[$];
    int   checks = 0;
    int   passed = 0;

`ifdef WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic chk_fwd(input string nm, input logic [ADDR_W-1:0] lk, input logic h,
                           input logic [DATA_W-1:0] fd);
        logic              eh = 1'b0;
        logic [DATA_W-1:0] ed = '0;
        if (BYPASS && lk != '0) begin
            foreach (model[i]) begin
                if (model[i].r == lk) begin
                    eh = 1'b1;
                    ed = model[i].d;
                end
            end
        end
        chk({nm, "_hit"}, h, eh);
        chk({nm, "_data"}, fd, ed);
    endtask

    // Monitor: compare against pending queue, pop on each observed write, then apply next push.
    task automatic monitor();
        int   n = model.size();
        ent_t e;
        chk("count", count, n);
        chk("in_ready", in_ready, n < DEPTH);
        chk("rf_write_enable", rf_write_enable, (n != 0) && !rf_busy);
        chk_fwd("lookup1", lookup1, hit1, fwd_data1);
        chk_fwd("lookup2", lookup2, hit2, fwd_data2);
        if (n == 0) begin
            chk("rf_write_idle", rf_write, 0);
            chk("rf_write_data_idle", rf_write_data, 0);
        end else begin
            chk("rf_write_head", rf_write, model[0].r);
            chk("rf_write_data_head", rf_write_data, model[0].d);
        end
        if (rf_write_enable === 1'b1) begin
            if (n == 0) chk("spurious_write", 1, 0);
            else e = model.pop_front();
        end
        if (in_valid && n < DEPTH && in_reg != '0) model.push_back('{r: in_reg, d: in_data});
    endtask

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) model.delete();
        else monitor();
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d,
                         input logic busy);
        in_valid = v;
        in_reg   = r;
        in_data  = d;
        rf_busy  = busy;
        step();
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_wen", rf_write_enable, 0);
        chk("rst_count", count, 0);
        chk("rst_rf_write", rf_write, 0);
        chk("rst_hit1", hit1, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // Single push, drained next cycle
        drive(1'b1, 5'd3, 32'hDEADBEEF, 1'b0);
        in_valid = 1'b0;
        chk("single_wen", rf_write_enable, 1);
        chk("single_reg", rf_write, 3);
        chk("single_data", rf_write_data, 32'hDEADBEEF);
        step();
        chk("single_count_after", count, 0);

        // Five offers while the write port is busy: only four fit
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                chk("full_count", count, 4);
                chk("full_in_ready", in_ready, 0);
            end
            drive(1'b1, ADDR_W'(10 + i), DATA_W'(100 + i), 1'b1);
        end
        in_valid = 1'b0;
        rf_busy  = 1'b0;
        repeat (5) step();
        chk("full_drained", count, 0);

        // Youngest match forwarding
        lookup1 = 5'd5;
        lookup2 = 5'd0;
        drive(1'b1, 5'd5, 32'd1, 1'b1);
        drive(1'b1, 5'd5, 32'd2, 1'b1);
        in_valid = 1'b0;
        #1;
        chk("fwd_hit1", hit1, BYPASS);
        chk("fwd_data1", fwd_data1, BYPASS ? 32'd2 : 32'd0);
        chk("fwd_hit2", hit2, 0);
        chk("fwd_data2", fwd_data2, 0);
        step();
        rf_busy = 1'b0;
        repeat (3) step();

        // Writes to $0 are dropped
        drive(1'b1, 5'd0, 32'd7, 1'b0);
        in_valid = 1'b0;
        chk("r0_count", count, 0);
        chk("r0_wen", rf_write_enable, 0);
        step();

        // Fill, then sustained push+pop across pointer wrap
        for (int i = 0; i < 4; i++) drive(1'b1, ADDR_W'(20 + i), $urandom, 1'b1);
        for (int i = 0; i < 12; i++) drive(1'b1, ADDR_W'($urandom_range(1, 31)), $urandom, 1'b0);
        chk("steady_count", count, 3);
        in_valid = 1'b0;
        repeat (4) step();

        // Random traffic with lookups aimed at a small register range
        for (int i = 0; i < 400; i++) begin
            lookup1 = ADDR_W'($urandom_range(0, 7));
            lookup2 = ADDR_W'($urandom_range(0, 7));
            drive($urandom_range(0, 9) < 7, ADDR_W'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 9) < 3);
        end
        in_valid = 1'b0;
        rf_busy  = 1'b0;
        repeat (6) step();

        // Asynchronous reset in the middle of a drain
        for (int i = 0; i < 3; i++) drive(1'b1, ADDR_W'(1 + i), DATA_W'(50 + i), 1'b1);
        in_valid = 1'b0;
        rf_busy  = 1'b0;
        lookup1  = 5'd1;
        #1;
        chk("pre_reset_count", count, 3);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_count", count, 0);
        chk("async_rst_wen", rf_write_enable, 0);
        chk("async_rst_rf_write", rf_write, 0);
        chk("async_rst_in_ready", in_ready, 1);
        chk("async_rst_hit1", hit1, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) step();
        chk("post_reset_count", count, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
